// File: rtl/shl16_pkg.sv
// Shared types and constants for the 16-bit left-shift sequencer.
// Holds the FSM state type and the shift-count clamp used at accept time.
package shl16_pkg;

  localparam int WIDTH = 16;
  localparam int SHW   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counts above WIDTH would only keep shifting zeros in, so they saturate.
  function automatic logic [SHW-1:0] clamp_shamt(input logic [SHW-1:0] shamt);
    logic [SHW-1:0] lim;
    lim = SHW'(WIDTH);
    if (shamt > lim) begin
      return lim;
    end else begin
      return shamt;
    end
  endfunction

endpackage

// File: rtl/shl16_seq_ctrl_if.sv
// Request/result bundle between the two shift clients and the sequencer.
// The sequencer takes the slave view; the client side takes the master view.
interface shl16_seq_ctrl_if;
  import shl16_pkg::*;

  logic [1:0]       i_req_valid;
  logic [1:0]       o_req_ready;
  logic [WIDTH-1:0] i_req_data0;
  logic [WIDTH-1:0] i_req_data1;
  logic [SHW-1:0]   i_req_shamt0;
  logic [SHW-1:0]   i_req_shamt1;
  logic             i_abort;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [WIDTH-1:0] o_res_data;
  logic             o_res_id;
  logic             o_busy;

  modport master (
    output i_req_valid, i_req_data0, i_req_data1, i_req_shamt0, i_req_shamt1,
    output i_abort, i_res_ready,
    input  o_req_ready, o_res_valid, o_res_data, o_res_id, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_data0, i_req_data1, i_req_shamt0, i_req_shamt1,
    input  i_abort, i_res_ready,
    output o_req_ready, o_res_valid, o_res_data, o_res_id, o_busy
  );

endinterface

// File: rtl/shl16_reg.sv
// Zero-fill left-shift register with synchronous clear, load and shift enable.
// Priority is clear > load > shift > hold.
module shl16_reg #(
  parameter int REG_W = shl16_pkg::WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [REG_W-1:0] i_d,
  output logic [REG_W-1:0] o_q
);

  logic [REG_W-1:0] r_q;

  // Data register: one bit per clock towards the MSB when shifting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= {REG_W{1'b0}};
    end else if (i_clr) begin
      r_q <= {REG_W{1'b0}};
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= {r_q[REG_W-2:0], 1'b0};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shl16_seq_ctrl.sv
// Round-robin sequencer for a shared 16-bit left-shift register: accepts one
// job at a time, shifts it for the clamped count and returns a tagged result.
module shl16_seq_ctrl
  import shl16_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  shl16_seq_ctrl_if.slave       io_bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_prio;
  logic             r_owner;
  logic [SHW-1:0]   r_cnt;

  logic             w_grant;
  logic [1:0]       w_req_ready;
  logic             w_accept;
  logic             w_res_hs;
  logic [WIDTH-1:0] w_grant_data;
  logic [SHW-1:0]   w_eff_cnt;
  logic             w_clr;
  logic             w_shift;
  logic [WIDTH-1:0] w_reg_q;

  // Arbiter: a lone requester wins outright, a tie goes to r_prio.
  always_comb begin
    if (io_bus.i_req_valid == 2'b11) begin
      w_grant = r_prio;
    end else if (io_bus.i_req_valid[1]) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end

    if (w_grant) begin
      w_grant_data = io_bus.i_req_data1;
      w_eff_cnt    = clamp_shamt(io_bus.i_req_shamt1);
    end else begin
      w_grant_data = io_bus.i_req_data0;
      w_eff_cnt    = clamp_shamt(io_bus.i_req_shamt0);
    end

    // Ready is gated by reset so nothing looks acceptable while held in reset.
    if (i_rst_n && (r_state == IDLE) && !io_bus.i_abort && (io_bus.i_req_valid != 2'b00)) begin
      w_req_ready = w_grant ? 2'b10 : 2'b01;
    end else begin
      w_req_ready = 2'b00;
    end

    w_accept = |(io_bus.i_req_valid & w_req_ready);
    w_res_hs = (r_state == DONE) && io_bus.i_res_ready;
    w_clr    = (r_state != IDLE) && (io_bus.i_abort || w_res_hs);
    w_shift  = (r_state == SHIFT);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; abort wins over normal progress in SHIFT and DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_eff_cnt != {SHW{1'b0}}) ? SHIFT : DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (io_bus.i_abort) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == SHW'(1)) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      DONE: begin
        if (io_bus.i_abort || w_res_hs) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs; result fields read zero outside DONE.
  always_comb begin
    io_bus.o_req_ready = w_req_ready;
    io_bus.o_busy      = (r_state != IDLE);
    io_bus.o_res_valid = (r_state == DONE);
    if (r_state == DONE) begin
      io_bus.o_res_data = w_reg_q;
      io_bus.o_res_id   = r_owner;
    end else begin
      io_bus.o_res_data = {WIDTH{1'b0}};
      io_bus.o_res_id   = 1'b0;
    end
  end

  // Remaining shift count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {SHW{1'b0}};
    end else if (w_clr) begin
      r_cnt <= {SHW{1'b0}};
    end else if (w_accept) begin
      r_cnt <= w_eff_cnt;
    end else if (w_shift) begin
      r_cnt <= r_cnt - SHW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Owner tag and round-robin pointer; an abort leaves both untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else if (w_accept) begin
      r_owner <= w_grant;
      r_prio  <= ~w_grant;
    end else begin
      r_owner <= r_owner;
      r_prio  <= r_prio;
    end
  end

  shl16_reg #(.REG_W(WIDTH)) u_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_d     (w_grant_data),
    .o_q     (w_reg_q)
  );

endmodule
